// File: rtl/clock_divider_ctrl_if.sv
// Config request port of the divided-clock controller: valid/ready handshake
// carrying an enable bit and a divide ratio.
interface clock_divider_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_en;
  logic [CNT_W-1:0] cfg_div;

  // Requester side: issues requests, observes ready
  modport master (
    output cfg_valid,
    output cfg_en,
    output cfg_div,
    input  cfg_ready
  );

  // Controller side: accepts requests, drives ready
  modport slave (
    input  cfg_valid,
    input  cfg_en,
    input  cfg_div,
    output cfg_ready
  );
endinterface

// File: rtl/clock_divider_ctrl.sv
// Run-time controller for a programmable divided clock. Ratio and enable
// changes are applied only on a divided-period boundary so clk_out never
// shows a truncated phase (reset excepted).
module clock_divider_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  clock_divider_ctrl_if.slave cfg,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] cur_div,
  output logic             clk_out,
  output logic             div_tick
);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pend_en;
  logic [CNT_W-1:0] pend_div;
  logic             ready_q;

  logic             xfer;
  logic             illegal;
  logic             take;
  logic             wrap;
  logic [CNT_W-1:0] cnt_inc;
  logic             do_apply;
  logic             do_latch;
  logic             apply_en;
  logic [CNT_W-1:0] apply_div;

  assign cfg.cfg_ready = ready_q;

  // High phase covers the first floor(N/2) counts of each period
  function automatic logic phase_hi(input logic [CNT_W-1:0] k,
                                    input logic [CNT_W-1:0] n);
    return k < (n >> 1);
  endfunction

  // Handshake decode, boundary detect and the request to apply at the boundary
  always_comb begin
    xfer      = cfg.cfg_valid & ready_q;
    illegal   = xfer & cfg.cfg_en & (cfg.cfg_div < DIV_MIN);
    take      = xfer & ~illegal;
    wrap      = (cnt == (cur_div - ONE));
    cnt_inc   = wrap ? '0 : cnt + ONE;
    do_apply  = (state == PEND) ? wrap : (take & wrap);
    do_latch  = (state == RUN) & take & ~wrap;
    apply_en  = (state == PEND) ? pend_en  : cfg.cfg_en;
    apply_div = (state == PEND) ? pend_div : cfg.cfg_div;
  end

  // Controller state, period counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= AUTO_START ? RUN : OFF;
      cnt      <= AUTO_START ? (DIV_RST - ONE) : '0;
      cur_div  <= DIV_RST;
      pend_en  <= 1'b0;
      pend_div <= DIV_RST;
      clk_out  <= 1'b0;
      div_tick <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      err <= illegal;
      case (state)
        OFF: begin
          cnt <= '0;
          if (take && cfg.cfg_en) begin
            state    <= RUN;
            cur_div  <= cfg.cfg_div;
            clk_out  <= 1'b1;
            div_tick <= 1'b1;
          end else begin
            clk_out  <= 1'b0;
            div_tick <= 1'b0;
          end
        end
        RUN, PEND: begin
          if (do_apply) begin
            cnt     <= '0;
            busy    <= 1'b0;
            ready_q <= 1'b1;
            if (apply_en) begin
              state    <= RUN;
              cur_div  <= apply_div;
              clk_out  <= 1'b1;
              div_tick <= 1'b1;
            end else begin
              state    <= OFF;
              clk_out  <= 1'b0;
              div_tick <= 1'b0;
            end
          end else begin
            cnt      <= cnt_inc;
            clk_out  <= phase_hi(cnt_inc, cur_div);
            div_tick <= (cnt_inc == '0);
            if (do_latch) begin
              state    <= PEND;
              pend_en  <= cfg.cfg_en;
              pend_div <= cfg.cfg_div;
              busy     <= 1'b1;
              ready_q  <= 1'b0;
            end
          end
        end
        default: begin
          state    <= OFF;
          cnt      <= '0;
          clk_out  <= 1'b0;
          div_tick <= 1'b0;
          busy     <= 1'b0;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed bench for clock_divider_ctrl: each stimulus step queues the
// hand-computed output expected in the following cycle; a monitor pops and
// compares at the falling edge.
module tb_clock_divider_ctrl;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] cur_div;
  logic             clk_out;
  logic             div_tick;

  clock_divider_ctrl_if #(.CNT_W(CNT_W)) cfg ();

  clock_divider_ctrl #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(2),
    .AUTO_START (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg     (cfg),
    .busy    (busy),
    .err     (err),
    .cur_div (cur_div),
    .clk_out (clk_out),
    .div_tick(div_tick)
  );

  typedef struct {
    int               id;
    int               cyc;
    logic             co;
    logic             tk;
    logic [CNT_W-1:0] cd;
    logic             bs;
    logic             er;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   step_n = 0;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation due in the current cycle
  exp_t e;
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc ||
          {clk_out, div_tick, cur_div, busy, err, cfg.cfg_ready} !==
          {e.co, e.tk, e.cd, e.bs, e.er, ~e.bs}) begin
        errors++;
        $display("FAIL step%0d cyc=%0d: got clk_out=%b tick=%b cur_div=%0d busy=%b err=%b ready=%b, want clk_out=%b tick=%b cur_div=%0d busy=%b err=%b ready=%b",
                 e.id, cyc, clk_out, div_tick, cur_div, busy, err, cfg.cfg_ready,
                 e.co, e.tk, e.cd, e.bs, e.er, ~e.bs);
      end
    end
  end

  // Drive inputs for one cycle and queue the outputs expected after the edge
  task automatic step(input logic r, v, en, input logic [CNT_W-1:0] div,
                      input logic co, tk, input logic [CNT_W-1:0] cd,
                      input logic bs, er);
    exp_t x;
    rst           = r;
    cfg.cfg_valid = v;
    cfg.cfg_en    = en;
    cfg.cfg_div   = div;
    step_n++;
    x.id  = step_n;
    x.cyc = cyc + 1;
    x.co  = co;
    x.tk  = tk;
    x.cd  = cd;
    x.bs  = bs;
    x.er  = er;
    q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic co, tk, input logic [CNT_W-1:0] cd, input logic bs);
    step(1'b0, 1'b0, 1'b0, '0, co, tk, cd, bs, 1'b0);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_en    = 1'b0;
    cfg.cfg_div   = '0;
    @(posedge clk);
    #2;

    // Reset, then AUTO_START at N=2
    step(1, 0, 0, 0, 0, 0, 2, 0, 0);
    idle(1, 1, 2, 0); idle(0, 0, 2, 0); idle(1, 1, 2, 0); idle(0, 0, 2, 0);

    // Boundary request N=4 (cnt=1)
    step(0, 1, 1, 4, 1, 1, 4, 0, 0);
    idle(1, 0, 4, 0); idle(0, 0, 4, 0); idle(0, 0, 4, 0);

    // Boundary request N=6 at cnt=3: no PEND
    step(0, 1, 1, 6, 1, 1, 6, 0, 0);
    idle(1, 0, 6, 0); idle(1, 0, 6, 0);
    idle(0, 0, 6, 0); idle(0, 0, 6, 0); idle(0, 0, 6, 0);

    // Back to N=4, advance to cnt=1
    step(0, 1, 1, 4, 1, 1, 4, 0, 0);
    idle(1, 0, 4, 0);

    // N=3 requested at cnt=1: PEND two cycles, then 1,0,0
    step(0, 1, 1, 3, 0, 0, 4, 1, 0);
    idle(0, 0, 4, 1);
    idle(1, 1, 3, 0); idle(0, 0, 3, 0); idle(0, 0, 3, 0);
    idle(1, 1, 3, 0); idle(0, 0, 3, 0); idle(0, 0, 3, 0);

    // Illegal ratios 1 and 0: err pulse, pattern uninterrupted
    step(0, 1, 1, 1, 1, 1, 3, 0, 1);
    idle(0, 0, 3, 0);
    step(0, 1, 1, 0, 0, 0, 3, 0, 1);
    idle(1, 1, 3, 0);

    // N=4 via PEND; second request while not ready is ignored
    step(0, 1, 1, 4, 0, 0, 3, 1, 0);
    step(0, 1, 1, 7, 0, 0, 3, 1, 0);
    idle(1, 1, 4, 0);

    // Disable at cnt=0: period completes, then OFF
    step(0, 1, 0, 0, 1, 0, 4, 1, 0);
    idle(0, 0, 4, 1); idle(0, 0, 4, 1);
    idle(0, 0, 4, 0); idle(0, 0, 4, 0);

    // OFF: disable is a no-op, illegal enable pulses err
    step(0, 1, 0, 0, 0, 0, 4, 0, 0);
    step(0, 1, 1, 1, 0, 0, 4, 0, 1);

    // OFF + enable N=6: high 3, low 3, starting next cycle
    step(0, 1, 1, 6, 1, 1, 6, 0, 0);
    idle(1, 0, 6, 0); idle(1, 0, 6, 0);
    idle(0, 0, 6, 0); idle(0, 0, 6, 0); idle(0, 0, 6, 0);
    idle(1, 1, 6, 0);

    // Same ratio at cnt=0: longest PEND (N-1), no visible change
    step(0, 1, 1, 6, 1, 0, 6, 1, 0);
    idle(1, 0, 6, 1);
    idle(0, 0, 6, 1); idle(0, 0, 6, 1); idle(0, 0, 6, 1);
    idle(1, 1, 6, 0);
    idle(1, 0, 6, 0); idle(1, 0, 6, 0);
    idle(0, 0, 6, 0); idle(0, 0, 6, 0); idle(0, 0, 6, 0);

    // N=8, then PEND, then reset with cfg_valid held high
    step(0, 1, 1, 8, 1, 1, 8, 0, 0);
    idle(1, 0, 8, 0); idle(1, 0, 8, 0);
    step(0, 1, 1, 4, 1, 0, 8, 1, 0);
    step(1, 1, 1, 5, 0, 0, 2, 0, 0);
    idle(1, 1, 2, 0); idle(0, 0, 2, 0); idle(1, 1, 2, 0); idle(0, 0, 2, 0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
